// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
//   NIBBLE_W  : width of one lookahead slice
//   state_t   : controller states (2-bit encoding)
//   cnt_width : width of the nibble counter for a given nibble count
package cla_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter only has to reach nibbles-1; keep at least one bit.
   function automatic int cnt_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/cla_nibble_add.sv
// Purely combinational 4-bit carry-lookahead slice.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   sum  : nibble sum
//   cout : carry out of bit 3
//   c3   : carry into bit 3 (present only when CLA_OVERFLOW_EN is defined)
module cla_nibble_add
   import cla_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
`ifdef CLA_OVERFLOW_EN
   ,
   output logic                c3
`endif
);

   logic [NIBBLE_W-1:0] p;
   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W:0]   c;

   assign p = a ^ b;
   assign g = a & b;

   // Every carry is formed directly from p/g and cin, no ripple.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign sum  = p ^ c[3:0];
   assign cout = c[4];

`ifdef CLA_OVERFLOW_EN
   assign c3 = c[3];
`endif

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single
// carry-lookahead slice, carry registered between nibbles.
// Optional feature macro: CLA_OVERFLOW_EN (adds out_ovf signed overflow flag).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready : result handshake (out_sum, out_cout[, out_ovf])
//   busy                : high while an operation is in RUN or DONE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one nibble per cycle, NIBBLES cycles
// DONE  | result valid and held; in_ready follows out_ready
module cla_nibble_serial_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
`ifdef CLA_OVERFLOW_EN
   output logic             out_ovf,
`endif
   output logic             busy
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = cnt_width(NIBBLES);

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
   end

   state_t              state;
   state_t              state_nx;

   logic [WIDTH-1:0]    a_sh;
   logic [WIDTH-1:0]    b_sh;
   logic [WIDTH-1:0]    sum_sh;
   logic                carry_q;
   logic [CNT_W-1:0]    cnt;
   logic                cout_q;

   logic [NIBBLE_W-1:0] nib_sum;
   logic                nib_cout;
   logic                accept;
   logic                last_nib;

`ifdef CLA_OVERFLOW_EN
   logic                nib_c3;
   logic                ovf_q;
`endif

   cla_nibble_add u_nib (
      .a    (a_sh[NIBBLE_W-1:0]),
      .b    (b_sh[NIBBLE_W-1:0]),
      .cin  (carry_q),
      .sum  (nib_sum),
      .cout (nib_cout)
`ifdef CLA_OVERFLOW_EN
      ,
      .c3   (nib_c3)
`endif
   );

   assign accept   = in_valid && in_ready;
   assign last_nib = (cnt == CNT_W'(NIBBLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) state_nx = RUN;
         end
         RUN: begin
            if (last_nib) state_nx = DONE;
         end
         DONE: begin
            if (out_ready) state_nx = accept ? RUN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // In DONE, in_ready follows out_ready combinationally so a new operand
   // can be taken on the same edge the result leaves (back-to-back).
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         RUN:  busy     = 1'b1;
         DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
      if (rst) in_ready = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         cout_q  <= 1'b0;
`ifdef CLA_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else if (accept) begin
         a_sh    <= in_a;
         b_sh    <= in_b;
         carry_q <= in_cin;
         cnt     <= '0;
      end else if (state == RUN) begin
         a_sh    <= a_sh >> NIBBLE_W;
         b_sh    <= b_sh >> NIBBLE_W;
         // Sum fills from the top so after NIBBLES shifts nibble 0 sits at LSB.
         sum_sh  <= {nib_sum, sum_sh[WIDTH-1:NIBBLE_W]};
         carry_q <= nib_cout;
         cnt     <= cnt + CNT_W'(1);
         if (last_nib) begin
            cout_q <= nib_cout;
`ifdef CLA_OVERFLOW_EN
            // On the top nibble, c3 is the carry into bit WIDTH-1.
            ovf_q  <= nib_c3 ^ nib_cout;
`endif
         end
      end
   end

   assign out_sum  = sum_sh;
   assign out_cout = cout_q;
`ifdef CLA_OVERFLOW_EN
   assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
module tb_cla_nibble_serial_adder;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         busy;
`ifdef CLA_OVERFLOW_EN
   logic         out_ovf;
`endif

   cla_nibble_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
`ifdef CLA_OVERFLOW_EN
      .out_ovf   (out_ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int           n_vec  = 0;
   int           n_miss = 0;
   int           n_in   = 0;
   int           n_out  = 0;
   logic         last_fi;
   logic         hold_pend = 1'b0;
   logic [W-1:0] hold_sum;
   logic         hold_cout;
   logic [W+1:0] sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // {ovf, cout, sum}
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
      logic [W:0] s;
      logic       ovf;
      s   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      return {ovf, s};
   endfunction

   // One clock: handshakes sampled at the falling edge, returns at posedge+1.
   task automatic tick();
      logic         fi;
      logic         fo;
      logic [W+1:0] e;
      @(negedge clk);
      if (hold_pend) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_sum", out_sum, hold_sum);
         chk("hold_cout", out_cout, hold_cout);
      end
      fi = in_valid && in_ready;
      fo = out_valid && out_ready;
      hold_pend = out_valid && !out_ready;
      hold_sum  = out_sum;
      hold_cout = out_cout;
      if (fo) begin
         chk("sb_nonempty", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sum", out_sum, e[W-1:0]);
            chk("cout", out_cout, e[W]);
`ifdef CLA_OVERFLOW_EN
            chk("ovf", out_ovf, e[W+1]);
`endif
         end
         n_out++;
      end
      if (fi) begin
         sb.push_back(model(in_a, in_b, in_cin));
         n_in++;
      end
      last_fi = fi;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic [W-1:0] es, input logic ec, input logic eo);
      int lat;
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
      chk("dir_in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'b1;
      chk("busy_run", busy, 1'b1);
      wait_valid(lat);
      chk("latency", lat, 4);
      chk("dir_sum", out_sum, es);
      chk("dir_cout", out_cout, ec);
`ifdef CLA_OVERFLOW_EN
      chk("dir_ovf", out_ovf, eo);
`else
      if (eo !== 1'b0 && eo !== 1'b1) chk("dir_eo_x", eo, 1'b0);
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("valid_drop", out_valid, 1'b0);
   endtask

   function automatic logic [W-1:0] pick_op();
      case ($urandom_range(0, 7))
         0: return 16'hFFFF;
         1: return 16'h0000;
         2: return 16'h8000;
         3: return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int cyc;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_cin = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1'b0);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_sum", out_sum, 16'h0000);
      chk("rst_out_cout", out_cout, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready_after", in_ready, 1'b1);
`ifdef CLA_OVERFLOW_EN
      chk("rst_ovf", out_ovf, 1'b0);
`endif

      run_directed(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_directed(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_directed(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Backpressure then back-to-back.
      in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_valid(lat);
      chk("bp_latency", lat, 4);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_sum", out_sum, 16'h5555);
      end
      in_a = 16'h0F0F; in_b = 16'h0101; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", in_ready, 1'b1);
      tick();
      chk("b2b_accepted", last_fi, 1'b1);
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b_valid_drop", out_valid, 1'b0);
      chk("b2b_busy", busy, 1'b1);
      wait_valid(lat);
      chk("b2b_latency", lat, 4);
      chk("b2b_sum", out_sum, 16'h1010);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset in the middle of RUN abandons the operation.
      in_a = 16'h1111; in_b = 16'h2222; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      sb.delete();
      hold_pend = 1'b0;
      chk("mid_rst_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("mid_rst_no_valid", out_valid, 1'b0);
      end

      run_directed(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

      // Random traffic with stalls on both sides.
      n_in = 0; n_out = 0;
      cyc = 0;
      while ((n_in < 2000 || sb.size() != 0) && cyc < 60000) begin
         in_valid  = (n_in < 2000) && ($urandom_range(0, 3) != 0);
         in_a      = pick_op();
         in_b      = pick_op();
         in_cin    = 1'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("rand_ops_in", n_in, 2000);
      chk("rand_ops_out", n_out, n_in);
      chk("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
